// File: rtl/xdiv_pkg.sv
// Shared types and decode helpers for the xdiv diversifying coprocessor.
// Holds the FSM state encoding, operation codes and the delay-mask decode.
package xdiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RNDWAIT,
    ST_DELAY,
    ST_EXEC,
    ST_DONE
  } state_t;

  localparam logic [2:0] OP_XOR    = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b001;
  localparam logic [2:0] OP_RDRAND = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;

  // Mask of s+1 low ones; callers truncate or extend to the sample width.
  function automatic logic [7:0] mask_decode(input logic [2:0] s);
    logic [8:0] m;
    m = (9'd1 << ({1'b0, s} + 4'd1)) - 9'd1;
    return m[7:0];
  endfunction

  function automatic logic op_supported(input logic [2:0] op);
    return (op <= OP_AND);
  endfunction

endpackage

// File: rtl/xdiv_lfsr.sv
// Free-running Galois LFSR with a configurable tap mask and an extra
// feedback input that lets external entropy perturb the sequence.
module xdiv_lfsr #(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(32'h6789ABCD),
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'h80200003)
) (
  input  logic             cop_clk,
  input  logic             rst,
  input  logic             extra_tap,
  output logic [WIDTH-1:0] value
);

  logic feedback;

  assign feedback = value[0] ^ extra_tap;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge cop_clk) begin
    if (rst) begin
      value <= SEED;
    end else begin
      value <= (value >> 1) ^ (feedback ? TAPS : '0);
    end
  end

endmodule

// File: rtl/xdiv_cop_gen2.sv
// Diversifying coprocessor: latches operands, waits a TRNG-driven delay, then
// executes XOR/ADD/SUB/AND/RDRAND. Define XDIV_DUMMY_OPS_EN for dummy DELAY ops.
module xdiv_cop_gen2
  import xdiv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              RW        = 8,
  parameter logic [6:0]      CUSOPCODE = 7'b0001011,
  parameter logic [XLEN-1:0] LFSR_SEED = XLEN'(32'h6789ABCD)
) (
  input  logic            cop_clk,
  input  logic            rst,
  input  logic            cop_valid,
  input  logic [31:0]     cop_insn,
  input  logic [XLEN-1:0] cop_rs1,
  input  logic [XLEN-1:0] cop_rs2,
  output logic            cop_ready,
  output logic            cop_wr,
  output logic            cop_wait,
  output logic [XLEN-1:0] cop_rd,
  output logic            trn_gen,
  input  logic            trn_rdy,
  input  logic [RW-1:0]   trn_rnd
);

  localparam logic [XLEN-1:0] LFSR_TAPS = (XLEN == 64) ? XLEN'(64'hD800_0000_0000_0000)
                                                       : XLEN'(64'h0000_0000_8020_0003);

  state_t            state;
  state_t            state_n;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic [6:0]        funct_q;
  logic [RW-1:0]     rnd;
  logic [RW-1:0]     cnt;
  logic [RW-1:0]     mask;
  logic [XLEN-1:0]   resreg;
  logic [XLEN-1:0]   prng;
  logic [XLEN-1:0]   rnd_ext;
  logic [2:0]        op;
  logic              supported;
  logic              accept;

  assign op        = funct_q[2:0];
  assign supported = op_supported(op);
  assign mask      = RW'(mask_decode(funct_q[5:3]));
  assign rnd_ext   = XLEN'(rnd);
  assign accept    = (state == ST_IDLE) && cop_valid && (cop_insn[6:0] == CUSOPCODE);
  assign cop_rd    = resreg;

  function automatic logic [XLEN-1:0] alu(input logic [2:0]      sel,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b,
                                          input logic [XLEN-1:0] r);
    case (sel)
      OP_XOR:    return a ^ b;
      OP_ADD:    return a + b;
      OP_SUB:    return a - b;
      OP_AND:    return a & b;
      OP_RDRAND: return r;
      default:   return '0;
    endcase
  endfunction

  // PRNG mixes in the parity of the last TRNG sample so its stream diverges per run.
  xdiv_lfsr #(
    .WIDTH (XLEN),
    .SEED  (LFSR_SEED),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .cop_clk   (cop_clk),
    .rst       (rst),
    .extra_tap (^rnd),
    .value     (prng)
  );

  always_ff @(posedge cop_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: every output and next-state gets a default first so no path infers a latch.
  always_comb begin
    state_n   = state;
    cop_ready = 1'b0;
    cop_wr    = 1'b0;
    cop_wait  = 1'b0;
    trn_gen   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Unsupported ops skip the TRNG and pass through EXEC to clear the result.
        if (accept) begin
          state_n = op_supported(cop_insn[27:25]) ? ST_RNDWAIT : ST_EXEC;
        end
      end
      ST_RNDWAIT: begin
        trn_gen  = 1'b1;
        cop_wait = 1'b1;
        if (trn_rdy) begin
          state_n = (op == OP_RDRAND) ? ST_EXEC : ST_DELAY;
        end
      end
      ST_DELAY: begin
        cop_wait = 1'b1;
        if (cnt == '0) begin
          state_n = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_n = ST_DONE;
      end
      ST_DONE: begin
        cop_ready = 1'b1;
        cop_wr    = supported;
        state_n   = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cop_clk) begin
    if (rst) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      funct_q <= '0;
      rnd     <= '0;
      cnt     <= '0;
      resreg  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            rs1_q   <= cop_rs1;
            rs2_q   <= cop_rs2;
            funct_q <= cop_insn[31:25];
          end
        end
        ST_RNDWAIT: begin
          if (trn_rdy) begin
            rnd <= trn_rnd;
            cnt <= funct_q[6] ? (trn_rnd & mask) : '0;
          end
        end
        ST_DELAY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
`ifdef XDIV_DUMMY_OPS_EN
          resreg <= alu(op, rs1_q, prng, rnd_ext);
`endif
        end
        ST_EXEC: begin
          resreg <= supported ? alu(op, rs1_q, rs2_q, rnd_ext) : '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef XDIV_DUMMY_OPS_EN
  logic unused_bits;
  assign unused_bits = ^cop_insn[24:7];
`else
  logic unused_bits;
  assign unused_bits = ^{cop_insn[24:7], prng};
`endif

endmodule

// File: tb/tb_xdiv_cop_gen2.sv
// Directed bench for xdiv_cop_gen2: a 32-bit and a 64-bit instance run in
// lockstep on shared control stimulus; expected values are hand-computed.
module tb_xdiv_cop_gen2;

  localparam logic [6:0] OPC = 7'b0001011;

  logic        cop_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cop_valid = 1'b0;
  logic [31:0] cop_insn = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        trn_rdy = 1'b0;
  logic [7:0]  trn_rnd = '0;

  logic        ready32, wr32, wait32, gen32;
  logic [31:0] rd32;
  logic        ready64, wr64, wait64, gen64;
  logic [63:0] rd64;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 cop_clk = ~cop_clk;

  xdiv_cop_gen2 dut32 (
    .cop_clk   (cop_clk),
    .rst       (rst),
    .cop_valid (cop_valid),
    .cop_insn  (cop_insn),
    .cop_rs1   (rs1[31:0]),
    .cop_rs2   (rs2[31:0]),
    .cop_ready (ready32),
    .cop_wr    (wr32),
    .cop_wait  (wait32),
    .cop_rd    (rd32),
    .trn_gen   (gen32),
    .trn_rdy   (trn_rdy),
    .trn_rnd   (trn_rnd)
  );

  xdiv_cop_gen2 #(.XLEN(64)) dut64 (
    .cop_clk   (cop_clk),
    .rst       (rst),
    .cop_valid (cop_valid),
    .cop_insn  (cop_insn),
    .cop_rs1   (rs1),
    .cop_rs2   (rs2),
    .cop_ready (ready64),
    .cop_wr    (wr64),
    .cop_wait  (wait64),
    .cop_rd    (rd64),
    .trn_gen   (gen64),
    .trn_rdy   (trn_rdy),
    .trn_rnd   (trn_rnd)
  );

  // Observation results of the most recent transaction.
  int          t_cyc;
  bit          t_gen;
  logic [31:0] t_rd32;
  logic [63:0] t_rd64;
  logic        t_wr;
  logic [31:0] t_mid;
  logic        t_after;

  // Issues one instruction from an IDLE cycle and records what the DUT does.
  // lat = number of trn_gen cycles before trn_rdy is pulsed (1 = first one).
  task automatic run_txn(input logic [6:0] funct, input logic [63:0] a, input logic [63:0] b,
                         input int lat, input logic [7:0] rnd);
    int gen_cnt;
    gen_cnt   = 0;
    t_cyc     = -1;
    t_gen     = 1'b0;
    t_rd32    = '0;
    t_rd64    = '0;
    t_wr      = 1'b0;
    t_mid     = '0;
    cop_insn  = {funct, 18'h0, OPC};
    rs1       = a;
    rs2       = b;
    cop_valid = 1'b1;
    @(posedge cop_clk); #1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (cyc == 4) t_mid = rd32;
      if (ready32) begin
        t_cyc  = cyc;
        t_rd32 = rd32;
        t_rd64 = rd64;
        t_wr   = wr32;
        break;
      end
      if (gen32) begin
        t_gen = 1'b1;
        gen_cnt++;
        if (gen_cnt == lat) begin
          trn_rdy = 1'b1;
          trn_rnd = rnd;
        end
      end
      @(posedge cop_clk); #1;
      trn_rdy = 1'b0;
    end
    cop_valid = 1'b0;
    trn_rdy   = 1'b0;
    @(posedge cop_clk); #1;
    t_after = ready32;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge cop_clk);
    #1;
    n_checks++;
    if ({ready32, wr32, wait32, gen32} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b want 0000", {ready32, wr32, wait32, gen32});
    else n_pass++;
    n_checks++;
    if (rd32 !== 32'h0 || rd64 !== 64'h0)
      $display("FAIL reset_rd: got %h/%h want 0/0", rd32, rd64);
    else n_pass++;
    rst = 1'b0;
    @(posedge cop_clk); #1;
    n_checks++;
    if ({ready32, wait32, gen32} !== 3'b000)
      $display("FAIL reset_idle: got %b want 000", {ready32, wait32, gen32});
    else n_pass++;
  endtask

  task automatic test_xor();
    run_txn(7'b0000000, 64'hF0F0F0F0, 64'h0FF00FF0, 1, 8'h3C);
    n_checks++;
    if (t_rd32 !== 32'hFF00FF00) $display("FAIL xor_rd: got %h want ff00ff00", t_rd32);
    else n_pass++;
    n_checks++;
    if (t_wr !== 1'b1) $display("FAIL xor_wr: got %b want 1", t_wr);
    else n_pass++;
    n_checks++;
    if (t_cyc != 4) $display("FAIL xor_latency: got %0d want 4", t_cyc);
    else n_pass++;
    n_checks++;
    if (t_after !== 1'b0) $display("FAIL xor_pulse: ready still %b next cycle want 0", t_after);
    else n_pass++;
  endtask

  task automatic test_add_delay();
    run_txn(7'b1010001, 64'hFFFFFFFF, 64'h2, 1, 8'hFD);
    n_checks++;
    if (t_rd32 !== 32'h00000001) $display("FAIL add_rd: got %h want 00000001", t_rd32);
    else n_pass++;
    n_checks++;
    if (t_cyc != 9) $display("FAIL add_latency: got %0d want 9", t_cyc);
    else n_pass++;
    n_checks++;
    if (t_rd64 !== 64'h1_00000001) $display("FAIL add_rd64: got %h want 100000001", t_rd64);
    else n_pass++;
`ifndef XDIV_DUMMY_OPS_EN
    n_checks++;
    if (t_mid !== 32'hFF00FF00) $display("FAIL add_hold: got %h want ff00ff00", t_mid);
    else n_pass++;
`endif
  endtask

  task automatic test_rdrand();
    // Stray sample in IDLE must be ignored.
    trn_rdy = 1'b1;
    trn_rnd = 8'h11;
    @(posedge cop_clk); #1;
    trn_rdy = 1'b0;
    run_txn(7'b0000010, 64'h0, 64'h0, 1, 8'hA5);
    n_checks++;
    if (t_rd32 !== 32'h000000A5 || t_rd64 !== 64'hA5)
      $display("FAIL rdrand_rd: got %h/%h want a5/a5", t_rd32, t_rd64);
    else n_pass++;
    n_checks++;
    if (t_cyc != 3) $display("FAIL rdrand_latency: got %0d want 3", t_cyc);
    else n_pass++;
    run_txn(7'b1111010, 64'h0, 64'h0, 2, 8'h3C);
    n_checks++;
    if (t_rd32 !== 32'h0000003C) $display("FAIL rdrand_l2_rd: got %h want 3c", t_rd32);
    else n_pass++;
    n_checks++;
    if (t_cyc != 4) $display("FAIL rdrand_l2_latency: got %0d want 4", t_cyc);
    else n_pass++;
  endtask

  task automatic test_unsupported();
    run_txn(7'b0000111, 64'h1234, 64'h5678, 1, 8'h55);
    n_checks++;
    if (t_cyc != 2) $display("FAIL unsup_latency: got %0d want 2", t_cyc);
    else n_pass++;
    n_checks++;
    if (t_wr !== 1'b0 || t_rd32 !== 32'h0)
      $display("FAIL unsup_result: got wr=%b rd=%h want wr=0 rd=0", t_wr, t_rd32);
    else n_pass++;
    n_checks++;
    if (t_gen !== 1'b0) $display("FAIL unsup_gen: got %b want 0", t_gen);
    else n_pass++;
  endtask

  task automatic test_sub_and();
    run_txn(7'b0000011, 64'h5, 64'h7, 1, 8'h00);
    n_checks++;
    if (t_rd32 !== 32'hFFFFFFFE || t_rd64 !== 64'hFFFFFFFF_FFFFFFFE)
      $display("FAIL sub_rd: got %h/%h want fffffffe/fffffffffffffffe", t_rd32, t_rd64);
    else n_pass++;
    run_txn(7'b1000100, 64'h12345678, 64'h0F0F0F0F, 1, 8'h03);
    n_checks++;
    if (t_rd32 !== 32'h02040608) $display("FAIL and_rd: got %h want 02040608", t_rd32);
    else n_pass++;
    n_checks++;
    if (t_cyc != 5) $display("FAIL and_latency: got %0d want 5", t_cyc);
    else n_pass++;
  endtask

  task automatic test_max_delay();
    run_txn(7'b1111000, 64'h1, 64'h3, 1, 8'hFF);
    n_checks++;
    if (t_cyc != 259) $display("FAIL maxdly_latency: got %0d want 259", t_cyc);
    else n_pass++;
    n_checks++;
    if (t_rd32 !== 32'h2) $display("FAIL maxdly_rd: got %h want 2", t_rd32);
    else n_pass++;
  endtask

  task automatic test_sub64();
    run_txn(7'b0000011, 64'h0, 64'h1, 1, 8'h81);
    n_checks++;
    if (t_rd64 !== 64'hFFFFFFFF_FFFFFFFF)
      $display("FAIL sub64_rd: got %h want ffffffffffffffff", t_rd64);
    else n_pass++;
    n_checks++;
    if (t_rd32 !== 32'hFFFFFFFF) $display("FAIL sub64_rd32: got %h want ffffffff", t_rd32);
    else n_pass++;
  endtask

  task automatic test_ignore();
    cop_insn  = {7'b0000001, 18'h0, 7'b0110011};
    cop_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge cop_clk); #1;
      n_checks++;
      if ({ready32, wait32, gen32} !== 3'b000 || rd32 !== 32'hFFFFFFFF)
        $display("FAIL ignore_opcode: got ctrl=%b rd=%h want 000/ffffffff",
                 {ready32, wait32, gen32}, rd32);
      else n_pass++;
    end
    cop_valid = 1'b0;
    @(posedge cop_clk); #1;
  endtask

  task automatic test_back_to_back();
    run_txn(7'b0000000, 64'hAAAA0000, 64'h0000AAAA, 1, 8'h01);
    n_checks++;
    if (t_rd32 !== 32'hAAAAAAAA || t_cyc != 4)
      $display("FAIL b2b_first: got rd=%h cyc=%0d want aaaaaaaa/4", t_rd32, t_cyc);
    else n_pass++;
    run_txn(7'b0000001, 64'h10, 64'h20, 1, 8'h02);
    n_checks++;
    if (t_rd32 !== 32'h30 || t_cyc != 4)
      $display("FAIL b2b_second: got rd=%h cyc=%0d want 30/4", t_rd32, t_cyc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    cop_insn  = {7'b1111000, 18'h0, OPC};
    rs1       = 64'h5;
    rs2       = 64'h3;
    cop_valid = 1'b1;
    @(posedge cop_clk); #1;
    trn_rdy = 1'b1;
    trn_rnd = 8'hFF;
    @(posedge cop_clk); #1;
    trn_rdy = 1'b0;
    n_checks++;
    if (wait32 !== 1'b1 || gen32 !== 1'b0)
      $display("FAIL rstmid_delay: got wait=%b gen=%b want 1/0", wait32, gen32);
    else n_pass++;
    repeat (2) @(posedge cop_clk);
    #1;
    rst       = 1'b1;
    cop_valid = 1'b0;
    @(posedge cop_clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({ready32, wr32, wait32, gen32} !== 4'b0000 || rd32 !== 32'h0 || rd64 !== 64'h0)
      $display("FAIL rstmid_outputs: got ctrl=%b rd=%h want 0000/0",
               {ready32, wr32, wait32, gen32}, rd32);
    else n_pass++;
    seen = 1'b0;
    repeat (300) begin
      @(posedge cop_clk); #1;
      if (ready32 || wait32) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL rstmid_no_ready: got activity=%b want 0", seen);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_xor();
    test_add_delay();
    test_rdrand();
    test_unsupported();
    test_sub_and();
    test_max_delay();
    test_sub64();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
